// File: rtl/trace_capture_if.sv
// rtl/trace_capture_if.sv - sample stream bundle between trace_capture and the trace DMA path
interface trace_capture_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - logic-analyzer front end: sync, decimate, trigger, stream samples
module trace_capture #(
    parameter int DATA_WIDTH  = 20,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [DATA_WIDTH-1:0]  trace_i,
    input  logic                   start,
    input  logic                   abort,
    input  logic [15:0]            sample_div,
    input  logic [COUNT_WIDTH-1:0] num_samples,
    input  logic [DATA_WIDTH-1:0]  trig_mask,
    input  logic [DATA_WIDTH-1:0]  trig_value,
    trace_capture_if.master        m_axis,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] sample_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;
    logic   done_next;

    logic [DATA_WIDTH-1:0]  sync_meta;
    logic [DATA_WIDTH-1:0]  sync_data;

    logic [15:0]            div_lat;
    logic [COUNT_WIDTH-1:0] num_lat;
    logic [DATA_WIDTH-1:0]  mask_lat;
    logic [DATA_WIDTH-1:0]  value_lat;
    logic [15:0]            div_cnt;

    logic running;
    logic accept;
    logic tick;
    logic match;
    logic capture;
    logic is_last;
    logic handshake;
    logic abort_run;

    assign running   = (state == ARMED) || (state == CAPTURE);
    assign accept    = (state == IDLE) && start && (num_samples != '0);
    assign tick      = running && (div_cnt == div_lat);
    assign match     = ((sync_data ^ value_lat) & mask_lat) == '0;
    assign abort_run = abort && (state != IDLE);
    assign capture   = tick && ((state == CAPTURE) || match) && !abort_run;
    // sample_count is cleared on arm, so in ARMED this reduces to num_lat == 1
    assign is_last   = (sample_count + COUNT_WIDTH'(1)) == num_lat;
    assign handshake = m_axis.tvalid && m_axis.tready;
    assign busy      = (state != IDLE);

    // State register and registered completion pulse
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Next-state logic; abort beats any same-cycle tick or handshake
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ARMED;
                end
            end
            ARMED, CAPTURE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (capture) begin
                    state_next = is_last ? DRAIN : CAPTURE;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (handshake) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Two-flop synchronizer for the asynchronous pin data
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_meta <= '0;
            sync_data <= '0;
        end else begin
            sync_meta <= trace_i;
            sync_data <= sync_meta;
        end
    end

    // Run configuration snapshot taken when a start is accepted
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            div_lat   <= '0;
            num_lat   <= '0;
            mask_lat  <= '0;
            value_lat <= '0;
        end else if (accept) begin
            div_lat   <= sample_div;
            num_lat   <= num_samples;
            mask_lat  <= trig_mask;
            value_lat <= trig_value;
        end
    end

    // Decimation counter, phase restarts at every arm
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            div_cnt <= '0;
        end else if (accept) begin
            div_cnt <= '0;
        end else if (running) begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
        end
    end

    // Output beat register, drop accounting and sample counter
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            overflow      <= 1'b0;
            sample_count  <= '0;
        end else if (abort_run) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
        end else begin
            if (accept) begin
                overflow     <= 1'b0;
                sample_count <= '0;
            end
            if (capture) begin
                sample_count <= sample_count + COUNT_WIDTH'(1);
                if (!m_axis.tvalid || m_axis.tready) begin
                    m_axis.tdata  <= 32'(sync_data);
                    m_axis.tvalid <= 1'b1;
                    m_axis.tlast  <= is_last;
                end else begin
                    // Pending beat is held; the new sample is lost, but if it
                    // was the final one the pending beat closes the run.
                    overflow <= 1'b1;
                    if (is_last) begin
                        m_axis.tlast <= 1'b1;
                    end
                end
            end else if (handshake) begin
                m_axis.tvalid <= 1'b0;
                m_axis.tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Logic-analyzer front end for the logictools overlay; consumes the 20 Arduino-shield input lines coming out of the top-level IOBUFs.
- Synchronizes the inputs, decimates them by a programmable divider, and waits for a masked-pattern trigger.
- Then streams a fixed number of samples as AXI4-Stream beats into the trace DMA path inside the system block design.

Parameters:
- DATA_WIDTH, 20, number of probed lines; legal range 1..32.
- COUNT_WIDTH, 16, width of the sample-count configuration and counter.

Ports:
- aclk  input  1  single clock for all logic.
- aresetn  input  1  reset: synchronous and active-low.
- trace_i  input  DATA_WIDTH  raw pin data from IOBUF O outputs; asynchronous to aclk.
- start  input  1  one-cycle arm request.
- abort  input  1  one-cycle cancel request.
- sample_div  input  16  sample every sample_div+1 aclk cycles.
- num_samples  input  COUNT_WIDTH  samples to capture per run.
- trig_mask  input  DATA_WIDTH  1 = bit participates in trigger.
- trig_value  input  DATA_WIDTH  trigger pattern.
- m_axis_tdata  output  32  sample, zero-extended.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  final beat of run.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse at normal run completion.
- overflow  output  1  sticky; a sample was dropped this run.
- sample_count  output  COUNT_WIDTH  samples taken this run, dropped samples included.

Behaviour:
- Reset (aresetn=0 at a rising edge): state=IDLE and every output 0 — tdata, tvalid, tlast, busy, done, overflow, sample_count. Synchronizer flops and divider counter also 0.
- Synchronizer: trace_i passes through a 2-flop synchronizer; sync_data lags trace_i by 2 cycles.
- Configuration: sample_div, num_samples, trig_mask and trig_value are latched when start is accepted. Later input changes have no effect mid-run.
- Divider: counter clears on entering ARMED. tick=1 when counter==div_latched; the counter then returns to 0, otherwise it increments. With div=0, tick occurs every cycle.
- Trigger match: (sync_data & mask) == (value & mask). With mask=0, the first tick matches.
- IDLE:
  - start with num_samples!=0 -> ARMED; overflow and sample_count clear.
  - start with num_samples==0 is ignored.
  - start in any other state is ignored.
- ARMED:
  - Tick with match: capture sync_data as sample 1.
  - Go to DRAIN if num_samples==1, else CAPTURE.
- CAPTURE:
  - Each tick captures sync_data and increments sample_count.
  - The tick that brings sample_count to num_samples marks tlast and moves to DRAIN.
- DRAIN: waits until the final beat handshakes (tvalid&tready), then goes to IDLE with done=1 for exactly that one cycle.
- Capture write:
  - tdata <= zero-extended sample, tvalid <= 1, tlast <= (this is the last sample).
  - Latency: trace_i pin change to tvalid is 2 sync cycles + 1 register stage, plus divider phase.
- Output handshake:
  - tvalid clears on handshake unless a capture happens in the same cycle.
  - Handshake + capture in the same cycle: the new sample loads and nothing is dropped.
  - tdata and tlast are stable while tvalid=1 and tready=0.
- Overflow:
  - A capture tick with tvalid=1, tready=0 drops the new sample.
  - overflow goes to 1 and sample_count still increments.
  - If the dropped sample is the last one, tlast is set on the pending beat instead and the state moves to DRAIN.
- Abort: in any non-IDLE state -> IDLE next cycle. tvalid and tlast clear, no done pulse; overflow and sample_count hold. Abort has priority over a same-cycle tick or handshake.
- Counter width: sample_count never wraps, because the run ends at num_samples ≤ 2^COUNT_WIDTH−1.

Test Plan:
- Immediate trigger: div=0, mask=0, num=4, tready=1, trace_i ramps 0,1,2,3,... per cycle -> 4 consecutive beats of consecutive values. tlast only on the 4th; done pulses 1 cycle after the 4th handshake; busy falls with done.
- Pattern trigger + decimation: div=3, mask=0xF, value=0x5, trace_i counts +1 per cycle from 0, num=3 -> beats 0x5, 0x9, 0xD, with tvalid rising every 4 cycles.
- Backpressure: div=0, num=8, tready held low after the first beat for 3 cycles -> overflow=1, sample_count=8, last pending beat carries tlast, done after the final handshake.
- Boundary single sample: num=1, mask=0xFFFFF, value=0xABCDE, pattern appears once -> exactly one beat 0x000ABCDE with tlast=1. start with num=0 -> busy stays 0.
- Abort/reset mid-run: abort in CAPTURE after 2 of 10 beats -> IDLE next cycle, tvalid=0, no done, start re-arms cleanly. aresetn=0 mid-capture -> all outputs 0 on the next edge.
